// File: rtl/game_ctrl.sv
// Game supervisor: IDLE/PLAY/HURT/OVER sequencing, lives, BCD score and best score.
// Every output comes straight from a register.
module game_ctrl #(
  parameter int unsigned START_LIVES  = 3,
  parameter logic [9:0]  FALL_Y       = 10'd470,
  parameter logic [7:0]  INVULN_TICKS = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        hit_ceiling,
  input  logic        floor_land,
  input  logic [9:0]  slime_y,
  output logic [1:0]  state,
  output logic        game_rst,
  output logic        freeze,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd
);

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HURT = 2'd2, OVER = 2'd3} state_t;

  state_t             st, st_nxt;
  logic               hit_prev;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         lives_nxt;
  logic [SCORE_W-1:0] score_nxt, high_nxt, score_inc;
  logic               hit_edge, fall, in_game;

  // Saturating 4-digit BCD increment.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign hit_edge  = hit_ceiling & ~hit_prev;
  assign fall      = (slime_y >= FALL_Y);
  assign in_game   = (st == PLAY) || (st == HURT);
  assign score_inc = (in_game && floor_land) ? bcd_inc(score_bcd) : score_bcd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    lives_nxt = lives;
    cnt_nxt   = cnt;
    score_nxt = score_bcd;
    high_nxt  = high_bcd;
    case (st)
      IDLE: begin
        if (start) begin
          st_nxt    = PLAY;
          score_nxt = '0;
          lives_nxt = 2'(START_LIVES);
        end
      end
      PLAY: begin
        score_nxt = score_inc;
        if (fall) begin
          st_nxt    = OVER;
          lives_nxt = 2'd0;
        end else if (hit_edge) begin
          if (lives > 2'd1) begin
            st_nxt    = HURT;
            lives_nxt = lives - 2'd1;
            cnt_nxt   = INVULN_TICKS;
          end else begin
            st_nxt    = OVER;
            lives_nxt = 2'd0;
          end
        end
      end
      HURT: begin
        score_nxt = score_inc;
        if (fall) begin
          st_nxt    = OVER;
          lives_nxt = 2'd0;
        end else if (tick) begin
          cnt_nxt = (cnt == '0) ? cnt : cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) st_nxt = PLAY;
        end
      end
      OVER: begin
        if (start) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    // Plain compare of valid BCD equals an MSD-first digit compare.
    if (st_nxt == OVER && st != OVER && score_nxt > high_bcd) high_nxt = score_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_prev  <= 1'b0;
      cnt       <= '0;
      lives     <= 2'd0;
      score_bcd <= '0;
      high_bcd  <= '0;
      game_rst  <= 1'b1;
      freeze    <= 1'b0;
    end else begin
      hit_prev  <= hit_ceiling;
      cnt       <= cnt_nxt;
      lives     <= lives_nxt;
      score_bcd <= score_nxt;
      high_bcd  <= high_nxt;
      game_rst  <= (st_nxt == IDLE);
      freeze    <= (st_nxt == OVER);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_ctrl.sv
// Scenario bench for game_ctrl with a score scoreboard queue.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst, tick, start, hit_ceiling, floor_land;
  logic [9:0]  slime_y;
  logic [1:0]  state, lives;
  logic        game_rst, freeze;
  logic [15:0] score_bcd, high_bcd;

  int checks = 0;
  int failures = 0;
  int ref_score = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .hit_ceiling(hit_ceiling),
    .floor_land(floor_land), .slime_y(slime_y), .state(state), .game_rst(game_rst),
    .freeze(freeze), .lives(lives), .score_bcd(score_bcd), .high_bcd(high_bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic land_n(input int n);
    floor_land = 1'b1;
    repeat (n) step();
    floor_land = 1'b0;
    ref_score = (ref_score + n > 9999) ? 9999 : ref_score + n;
    exp_q.push_back(to_bcd(ref_score));
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic restart();
    start = 1'b1; step();
    step();
    start = 1'b0;
    ref_score = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; start = 0; hit_ceiling = 0; floor_land = 0; slime_y = 10'd100;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({state, game_rst, freeze, lives, score_bcd, high_bcd} !== {2'd0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset: st=%0d grst=%b frz=%b lives=%0d score=%h high=%h", state, game_rst, freeze, lives, score_bcd, high_bcd);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_start();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({state, lives, score_bcd, game_rst} !== {2'd1, 2'd3, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL start: st=%0d lives=%0d score=%h grst=%b want 1/3/0000/0", state, lives, score_bcd, game_rst);
    end
    ref_score = 0;
  endtask

  task automatic test_score();
    land_n(12);
    exp_v = exp_q.pop_front();
    checks++;
    if (score_bcd !== exp_v) begin
      failures++;
      $display("FAIL score12: got %h want %h", score_bcd, exp_v);
    end
  endtask

  task automatic test_hit();
    hit_ceiling = 1'b1;
    repeat (10) step();
    hit_ceiling = 1'b0;
    checks++;
    if ({state, lives} !== {2'd2, 2'd2}) begin
      failures++;
      $display("FAIL hit_held: st=%0d lives=%0d want 2/2", state, lives);
    end
    ticks(63);
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("FAIL invuln63: st=%0d want 2", state);
    end
    ticks(1);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL invuln64: st=%0d want 1", state);
    end
    hit_ceiling = 1'b1; step(); hit_ceiling = 1'b0;
    checks++;
    if ({state, lives} !== {2'd2, 2'd1}) begin
      failures++;
      $display("FAIL hit2: st=%0d lives=%0d want 2/1", state, lives);
    end
    ticks(64);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL recover2: st=%0d want 1", state);
    end
  endtask

  task automatic test_last_life();
    hit_ceiling = 1'b1; floor_land = 1'b1; step();
    hit_ceiling = 1'b0; floor_land = 1'b0;
    ref_score++;
    exp_q.push_back(to_bcd(ref_score));
    exp_v = exp_q.pop_front();
    checks++;
    if ({state, lives, score_bcd, high_bcd, freeze} !== {2'd3, 2'd0, exp_v, exp_v, 1'b1}) begin
      failures++;
      $display("FAIL last_life: st=%0d lives=%0d score=%h high=%h frz=%b want 3/0/%h/%h/1", state, lives, score_bcd, high_bcd, freeze, exp_v, exp_v);
    end
  endtask

  task automatic test_over_restart();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({state, game_rst, score_bcd, freeze} !== {2'd0, 1'b1, 16'h0013, 1'b0}) begin
      failures++;
      $display("FAIL over_idle: st=%0d grst=%b score=%h frz=%b want 0/1/0013/0", state, game_rst, score_bcd, freeze);
    end
    start = 1'b1; step(); start = 1'b0;
    ref_score = 0;
    checks++;
    if ({state, score_bcd, high_bcd, lives} !== {2'd1, 16'h0, 16'h0013, 2'd3}) begin
      failures++;
      $display("FAIL replay: st=%0d score=%h high=%h lives=%0d want 1/0000/0013/3", state, score_bcd, high_bcd, lives);
    end
  endtask

  task automatic test_fall();
    hit_ceiling = 1'b1; step(); hit_ceiling = 1'b0;
    slime_y = 10'd469; step();
    checks++;
    if ({state, lives} !== {2'd2, 2'd2}) begin
      failures++;
      $display("FAIL fall469: st=%0d lives=%0d want 2/2", state, lives);
    end
    slime_y = 10'd470; step(); slime_y = 10'd100;
    checks++;
    if ({state, lives, high_bcd} !== {2'd3, 2'd0, 16'h0013}) begin
      failures++;
      $display("FAIL fall470: st=%0d lives=%0d high=%h want 3/0/0013", state, lives, high_bcd);
    end
  endtask

  task automatic test_saturate();
    restart();
    land_n(9999);
    exp_v = exp_q.pop_front();
    checks++;
    if (score_bcd !== exp_v) begin
      failures++;
      $display("FAIL score9999: got %h want %h", score_bcd, exp_v);
    end
    land_n(1);
    exp_v = exp_q.pop_front();
    checks++;
    if (score_bcd !== exp_v) begin
      failures++;
      $display("FAIL saturate: got %h want %h", score_bcd, exp_v);
    end
    slime_y = 10'd600; step(); slime_y = 10'd100;
    checks++;
    if ({state, high_bcd} !== {2'd3, 16'h9999}) begin
      failures++;
      $display("FAIL high9999: st=%0d high=%h want 3/9999", state, high_bcd);
    end
  endtask

  task automatic test_async_reset();
    restart();
    land_n(5);
    exp_v = exp_q.pop_front();
    checks++;
    if (score_bcd !== exp_v) begin
      failures++;
      $display("FAIL pre_reset: got %h want %h", score_bcd, exp_v);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({state, game_rst, freeze, lives, score_bcd, high_bcd} !== {2'd0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL async_rst: st=%0d grst=%b frz=%b lives=%0d score=%h high=%h", state, game_rst, freeze, lives, score_bcd, high_bcd);
    end
    step();
    rst = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({state, lives, score_bcd, high_bcd} !== {2'd1, 2'd3, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL post_rst: st=%0d lives=%0d score=%h high=%h want 1/3/0000/0000", state, lives, score_bcd, high_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_hit();
    test_last_life();
    test_over_restart();
    test_fall();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter START_LIVES, default 3: lives loaded on game start (1..3).
REQ-002 Parameter FALL_Y, default 10'd470: slime_y threshold meaning "fell off bottom".
REQ-003 Parameter INVULN_TICKS, default 8'd64: tick count of invulnerability after a ceiling hit.
REQ-004 clk  input  1  system clock, single clock domain for all state.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-clk game-step strobe, synchronous to clk.
REQ-007 start  input  1  one-clk pulse from keyboard start key.
REQ-008 hit_ceiling  input  1  level from floor generator, slime touching ceiling.
REQ-009 floor_land  input  1  one-clk pulse, slime landed on a new floor.
REQ-010 slime_y  input  10  slime vertical position, pixels.
REQ-011 state  output  2  IDLE=0, PLAY=1, HURT=2, OVER=3.
REQ-012 game_rst  output  1  active-high hold-in-reset for floor/slime movers.
REQ-013 freeze  output  1  high while game is over; movers stop stepping.
REQ-014 lives  output  2  remaining lives.
REQ-015 score_bcd  output  16  current score, 4 BCD digits.
REQ-016 high_bcd  output  16  best score since reset, 4 BCD digits.

Function
REQ-017 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-018 game_rst SHALL be 1 in IDLE, 0 otherwise; freeze SHALL be 1 in OVER, 0 otherwise.
REQ-019 IDLE: start=1 -> PLAY next cycle; score_bcd cleared to 0, lives loaded with START_LIVES in the same edge.
REQ-020 hit_ceiling SHALL be rising-edge detected internally (registered previous value); only the 0->1 edge counts as a hit.
REQ-021 PLAY, hit edge with lives>1 -> HURT, lives decremented by 1, invulnerability counter loaded with INVULN_TICKS.
REQ-022 PLAY, hit edge with lives==1 -> OVER, lives=0.
REQ-023 PLAY or HURT, slime_y >= FALL_Y -> OVER, lives=0, regardless of lives remaining; fall takes priority over a simultaneous hit.
REQ-024 HURT: hit edges ignored; counter decrements on each tick; tick with counter==1 -> PLAY on that edge.
REQ-025 floor_land in PLAY or HURT SHALL increment score_bcd by 1 with per-digit BCD carry (9->0, carry to next digit).
REQ-026 score_bcd SHALL saturate at 9999; floor_land at 9999 leaves it unchanged.
REQ-027 floor_land in the same cycle as a hit or fall SHALL still be scored.
REQ-028 On the edge entering OVER, high_bcd SHALL take the post-increment score if greater than high_bcd (4-digit BCD magnitude compare, MSD first).
REQ-029 OVER: start=1 -> IDLE next cycle; score_bcd and lives hold until the next IDLE->PLAY.
REQ-030 start in PLAY or HURT SHALL be ignored; floor_land, tick and hit in IDLE or OVER SHALL be ignored.
REQ-031 The edge detector register SHALL update every cycle in every state, so a hit level held across a state change does not re-fire.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, game_rst=1, freeze=0, lives=0, score_bcd=0, high_bcd=0, counter=0, edge register=0.
REQ-033 Reset asserted mid-game SHALL discard score and high score; first start after release behaves as REQ-019.

Verification
REQ-034 Reset release, start pulse -> state=1, lives=3, score_bcd=16'h0000, game_rst=0 one cycle later.
REQ-035 PLAY, 12 floor_land pulses -> score_bcd=16'h0012; with preload via 9999 lands, one more pulse -> stays 16'h9999.
REQ-036 PLAY, hit_ceiling held high 10 cycles -> exactly one hit: lives 3->2, state=2; 64 ticks later state=1; second edge -> lives=1.
REQ-037 lives=1, hit edge plus floor_land same cycle -> state=3, lives=0, score +1, high_bcd updated, freeze=1.
REQ-038 HURT, slime_y=470 -> state=3 next cycle with lives=0; slime_y=469 -> no change.
REQ-039 OVER, start -> IDLE, game_rst=1; start -> PLAY with score cleared, high_bcd retained; rst=0 mid-PLAY -> all REQ-032 values asynchronously.
